// File: rtl/handover_ctrl.sv
// Mobile-side handover controller: picks a candidate base station using hysteresis and
// time-to-trigger, runs the request/respond handshake with a timeout, and commits the new target.
module handover_ctrl #(
    parameter logic [1:0]  INIT_TARGET = 2'd1,
    parameter logic [7:0]  HYST        = 8'd8,
    parameter int unsigned TTT         = 4,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned GUARD       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       compare_enable,
    input  logic [7:0] signalquality1,
    input  logic [7:0] signalquality2,
    input  logic [7:0] signalquality3,
    input  logic       BS1_DM_respond,
    input  logic       BS2_DM_respond,
    input  logic       BS3_DM_respond,
    output logic [1:0] MD_DM_target,
    output logic       HO_BS1_request,
    output logic       HO_BS2_request,
    output logic       HO_BS3_request,
    output logic       ho_busy,
    output logic       ho_done,
    output logic [7:0] ho_fail_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_REQUEST, ST_GUARD} state_t;

    localparam logic [15:0] TTT_C      = 16'(TTT);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD - 1);

    state_t      state_q, state_d;
    logic [1:0]  cand_q, cand_d;
    logic [1:0]  target_q, target_d;
    logic [15:0] ttt_cnt_q, ttt_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [15:0] guard_cnt_q, guard_cnt_d;
    logic [7:0]  fail_q, fail_d;
    logic [2:0]  req_q, req_d;
    logic        busy_q, done_q, done_d;

    logic [7:0]  sq_serv, sq_a, sq_b;
    logic [1:0]  idx_a, idx_b, best;
    logic        qualify, cand_resp;

    // Non-serving pair is ordered low index first, so a tie resolves to the lower BS.
    always_comb begin
        sq_serv = signalquality1;
        sq_a    = signalquality2;
        sq_b    = signalquality3;
        idx_a   = 2'd2;
        idx_b   = 2'd3;
        case (target_q)
            2'd2: begin
                sq_serv = signalquality2;
                sq_a = signalquality1; idx_a = 2'd1;
                sq_b = signalquality3; idx_b = 2'd3;
            end
            2'd3: begin
                sq_serv = signalquality3;
                sq_a = signalquality1; idx_a = 2'd1;
                sq_b = signalquality2; idx_b = 2'd2;
            end
            default: ;
        endcase
        if (sq_b > sq_a) begin
            best    = idx_b;
            qualify = {1'b0, sq_b} >= ({1'b0, sq_serv} + {1'b0, HYST});
        end else begin
            best    = idx_a;
            qualify = {1'b0, sq_a} >= ({1'b0, sq_serv} + {1'b0, HYST});
        end
    end

    always_comb begin
        case (cand_q)
            2'd1:    cand_resp = BS1_DM_respond;
            2'd2:    cand_resp = BS2_DM_respond;
            2'd3:    cand_resp = BS3_DM_respond;
            default: cand_resp = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        target_d    = target_q;
        ttt_cnt_d   = ttt_cnt_q;
        to_cnt_d    = to_cnt_q;
        guard_cnt_d = guard_cnt_q;
        fail_d      = fail_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (compare_enable && qualify) begin
                    cand_d    = best;
                    ttt_cnt_d = 16'd1;
                    to_cnt_d  = '0;
                    state_d   = (TTT_C == 16'd1) ? ST_REQUEST : ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (compare_enable) begin
                    if (qualify && best == cand_q) begin
                        ttt_cnt_d = ttt_cnt_q + 16'd1;
                        if (ttt_cnt_d == TTT_C) begin
                            to_cnt_d = '0;
                            state_d  = ST_REQUEST;
                        end
                    end else begin
                        ttt_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_REQUEST: begin
                if (cand_resp) begin
                    target_d    = cand_q;
                    done_d      = 1'b1;
                    guard_cnt_d = '0;
                    ttt_cnt_d   = '0;
                    state_d     = ST_GUARD;
                end else if (to_cnt_q == TO_LAST) begin
                    if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
                    ttt_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    guard_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_d = '0;
        if (state_d == ST_REQUEST) begin
            case (cand_d)
                2'd1:    req_d = 3'b001;
                2'd2:    req_d = 3'b010;
                2'd3:    req_d = 3'b100;
                default: req_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cand_q      <= '0;
            target_q    <= INIT_TARGET;
            ttt_cnt_q   <= '0;
            to_cnt_q    <= '0;
            guard_cnt_q <= '0;
            fail_q      <= '0;
            req_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            target_q    <= target_d;
            ttt_cnt_q   <= ttt_cnt_d;
            to_cnt_q    <= to_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            fail_q      <= fail_d;
            req_q       <= req_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
        end
    end

    assign MD_DM_target   = target_q;
    assign HO_BS1_request = req_q[0];
    assign HO_BS2_request = req_q[1];
    assign HO_BS3_request = req_q[2];
    assign ho_busy        = busy_q;
    assign ho_done        = done_q;
    assign ho_fail_cnt    = fail_q;

endmodule

// File: tb/tb_handover_ctrl.sv
// Directed bench for handover_ctrl: hysteresis, time-to-trigger, handshake, timeout,
// saturation and asynchronous reset, with hand-computed expectations.
module tb_handover_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       compare_enable;
    logic [7:0] sq1, sq2, sq3;
    logic       r1, r2, r3;
    logic [1:0] target;
    logic       q1, q2, q3;
    logic       busy, done;
    logic [7:0] fails;

    int n_vec  = 0;
    int n_miss = 0;
    int hi;

    always #5 clk = ~clk;

    handover_ctrl #(
        .INIT_TARGET(2'd1),
        .HYST(8'd8),
        .TTT(4),
        .TIMEOUT(16),
        .GUARD(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .compare_enable(compare_enable),
        .signalquality1(sq1),
        .signalquality2(sq2),
        .signalquality3(sq3),
        .BS1_DM_respond(r1),
        .BS2_DM_respond(r2),
        .BS3_DM_respond(r3),
        .MD_DM_target(target),
        .HO_BS1_request(q1),
        .HO_BS2_request(q2),
        .HO_BS3_request(q3),
        .ho_busy(busy),
        .ho_done(done),
        .ho_fail_cnt(fails)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] reqv();
        return {13'd0, q3, q2, q1};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        reset = 1'b0; compare_enable = 1'b0;
        sq1 = 8'd100; sq2 = 8'd100; sq3 = 8'd100;
        r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;

        // Reset values
        tick(3);
        check("rst_target", 16'(target), 16'd1);
        check("rst_req", reqv(), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_fail", 16'(fails), 16'd0);
        reset = 1'b1;
        compare_enable = 1'b1;
        tick(5);
        check("equal_sq_idle", 16'(busy), 16'd0);

        // Hysteresis boundary: 107 is one short of 100+8
        sq2 = 8'd107; sq3 = 8'd0;
        tick(10);
        check("hyst107_busy", 16'(busy), 16'd0);
        check("hyst107_req", reqv(), 16'd0);
        sq2 = 8'd108;
        tick(3);
        check("ttt3_busy", 16'(busy), 16'd1);
        check("ttt3_noreq", reqv(), 16'd0);
        tick(1);
        check("ttt4_req2", reqv(), 16'b010);
        tick(2);
        check("req2_held", reqv(), 16'b010);
        check("tgt_before_commit", 16'(target), 16'd1);
        r2 = 1'b1;
        tick(1);
        r2 = 1'b0;
        check("commit_target", 16'(target), 16'd2);
        check("commit_done", 16'(done), 16'd1);
        check("commit_reqoff", reqv(), 16'd0);
        check("commit_busy", 16'(busy), 16'd1);
        tick(1);
        check("done_one_cycle", 16'(done), 16'd0);
        tick(6);
        check("guard_8th_busy", 16'(busy), 16'd1);
        tick(1);
        check("guard_exit_idle", 16'(busy), 16'd0);

        // TTT interruption (serving BS2, quality 100)
        sq1 = 8'd0; sq2 = 8'd100; sq3 = 8'd200;
        tick(2);
        check("measure_busy", 16'(busy), 16'd1);
        sq3 = 8'd50;
        tick(1);
        check("interrupt_idle", 16'(busy), 16'd0);
        tick(3);
        check("interrupt_noreq", reqv(), 16'd0);

        // compare_enable gaps inside MEASURE
        sq3 = 8'd200;
        tick(1);
        compare_enable = 1'b0;
        tick(2);
        check("gap_hold_busy", 16'(busy), 16'd1);
        compare_enable = 1'b1; tick(1);
        compare_enable = 1'b0; tick(3);
        compare_enable = 1'b1; tick(1);
        check("gap_3_noreq", reqv(), 16'd0);
        tick(1);
        check("gap_4_req3", reqv(), 16'b100);

        // Timeout: request held for exactly 16 cycles
        hi = 0;
        while (reqv() == 16'b100 && hi < 40) begin
            hi++;
            tick(1);
        end
        check("timeout_req_cycles", 16'(hi), 16'd16);
        check("timeout_fail1", 16'(fails), 16'd1);
        check("timeout_target", 16'(target), 16'd2);
        check("timeout_idle", 16'(busy), 16'd0);

        // 299 more timeouts of 20 cycles each (4 TTT + 16 REQUEST)
        tick(299 * 20);
        check("fail_saturate", 16'(fails), 16'd255);
        check("sat_target", 16'(target), 16'd2);
        compare_enable = 1'b0;

        // Wrong respond ignored; candidate respond on the timeout cycle wins
        do_reset();
        sq1 = 8'd100; sq2 = 8'd200; sq3 = 8'd0;
        compare_enable = 1'b1;
        tick(4);
        compare_enable = 1'b0;
        check("cand2_req", reqv(), 16'b010);
        r3 = 1'b1;
        tick(15);
        check("wrong_resp_req", reqv(), 16'b010);
        check("wrong_resp_target", 16'(target), 16'd1);
        r2 = 1'b1;
        tick(1);
        r2 = 1'b0; r3 = 1'b0;
        check("late_commit_target", 16'(target), 16'd2);
        check("late_commit_done", 16'(done), 16'd1);
        check("late_commit_fail", 16'(fails), 16'd0);
        check("late_commit_req", reqv(), 16'd0);
        tick(10);

        // Saturation guard: 255 < 250+8 without 8-bit wrap
        do_reset();
        sq1 = 8'd250; sq2 = 8'd255; sq3 = 8'd255;
        compare_enable = 1'b1;
        tick(6);
        check("nowrap_idle", 16'(busy), 16'd0);
        check("nowrap_noreq", reqv(), 16'd0);
        // Tie: BS2 preferred over BS3
        sq1 = 8'd0; sq2 = 8'd200; sq3 = 8'd200;
        tick(4);
        check("tie_req2", reqv(), 16'b010);
        compare_enable = 1'b0;
        r2 = 1'b1;
        tick(1);
        r2 = 1'b0;
        check("tie_commit", 16'(target), 16'd2);
        tick(8);

        // Mid-handshake asynchronous reset with target away from INIT_TARGET
        sq1 = 8'd0; sq2 = 8'd0; sq3 = 8'd200;
        compare_enable = 1'b1;
        tick(4);
        check("pre_reset_req3", reqv(), 16'b100);
        #2 reset = 1'b0;
        #1;
        check("async_rst_req", reqv(), 16'd0);
        check("async_rst_target", 16'(target), 16'd1);
        check("async_rst_busy", 16'(busy), 16'd0);
        compare_enable = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        check("post_rst_idle", 16'(busy), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/handover_ctrl.md
# handover_ctrl

Handover decision and sequencing controller for the mobile-device side of the handover system. Compares the three signal-quality measurements against the serving base station with hysteresis and time-to-trigger. Runs a request/respond handshake with the chosen candidate base station, with timeout. Commits the new serving target that drives `MD_DM_target` toward the demux.

## Interface
Parameters:
- `INIT_TARGET`, 2'd1: serving target after reset (1=BS1, 2=BS2, 3=BS3; 0 illegal).
- `HYST`, 8'd8: hysteresis margin on signal quality.
- `TTT`, 4: time-to-trigger in qualifying compare cycles (≥1).
- `TIMEOUT`, 16: max cycles waiting for respond (≥1).
- `GUARD`, 8: cycles of post-handover hold-off (≥1).

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `compare_enable` input 1: measurement valid strobe.
- `signalquality1/2/3` input 8 each: unsigned quality for BS1/BS2/BS3.
- `BS1_DM_respond`, `BS2_DM_respond`, `BS3_DM_respond` input 1 each: handover accept from each BS.
- `MD_DM_target` output 2: committed serving target.
- `HO_BS1_request`, `HO_BS2_request`, `HO_BS3_request` output 1 each: handover request to candidate; at most one high.
- `ho_busy` output 1: high in any state except IDLE.
- `ho_done` output 1: one-cycle pulse on commit.
- `ho_fail_cnt` output 8: saturating count of timed-out requests.

## Operation
- Candidate selection, combinational each cycle:
  - Best of the two non-serving qualities; on a tie, the lower BS index wins.
  - Qualifies iff `{1'b0,sq_cand} >= {1'b0,sq_serv} + HYST`. Arithmetic is 9-bit, with no wrap.
- States: IDLE, MEASURE, REQUEST, GUARD. Encoding is free.
- IDLE:
  - On `compare_enable`=1 with a qualifying candidate: latch the candidate and set `ttt_cnt`=1.
  - Then go to REQUEST if TTT==1, else go to MEASURE.
- MEASURE:
  - Cycles with `compare_enable`=0 hold all state.
  - On `compare_enable`=1:
    - Same latched candidate still qualifies: increment `ttt_cnt`, and go to REQUEST when the incremented value equals TTT.
    - Otherwise (no longer qualifies, or the best candidate changed): go to IDLE and clear `ttt_cnt`.
- REQUEST:
  - The latched candidate's `HO_BSx_request` is held high. `to_cnt` counts cycles spent in REQUEST, starting at 0.
  - Candidate's respond sampled high: `MD_DM_target` <= candidate, request deasserted, `ho_done` pulsed, go to GUARD.
  - Responds from non-candidate BSs are ignored.
  - No respond and `to_cnt`==TIMEOUT-1: deassert request, increment `ho_fail_cnt` (saturates at 255), go to IDLE.
  - Respond and timeout in the same cycle: respond wins.
- GUARD:
  - Counts GUARD cycles, then returns to IDLE. Measurements are ignored meanwhile.
- Target changes only via a commit in REQUEST.

## Timing
- Reset asserted (`reset`=0), asynchronous, effective immediately, including mid-handshake:
  - State IDLE, `MD_DM_target`=INIT_TARGET, all requests 0.
  - `ho_busy`=0, `ho_done`=0, `ho_fail_cnt`=0, all counters 0.
- All outputs are registered; no combinational input-to-output path.
- Request rises on the clock edge that enters REQUEST.
  - TTT=4 with continuous `compare_enable`: request is high 4 cycles after the first qualifying sample edge.
- Commit latency:
  - `MD_DM_target`, `ho_done`=1 and request=0 appear on the edge that samples respond=1.
  - `ho_done` lasts exactly one cycle.
- Timeout: request is high for exactly TIMEOUT cycles, then drops. `ho_fail_cnt` updates on the same edge.
- GUARD lasts exactly GUARD cycles. The first IDLE cycle can accept a new qualifying sample.
- `ho_busy` is registered with the state; high from the cycle after leaving IDLE until the cycle IDLE is re-entered.

## Test plan
- Reset values:
  - Stimulus: hold `reset`=0, then release; all sq=100.
  - Required: target=1, no requests, `ho_busy`=0, `ho_fail_cnt`=0, stays IDLE.
- Hysteresis boundary:
  - Setup: serving BS1, sq1=100.
  - sq2=107, continuous compare: no handover.
  - sq2=108, continuous compare: `HO_BS2_request` high after 4 qualifying samples.
  - Respond BS2 after 3 cycles: target=2, `ho_done` one-cycle pulse, 8 GUARD cycles, then IDLE.
- TTT interruption:
  - sq3=200 for 2 samples, then sq3=50: back to IDLE, no request.
  - `compare_enable`=0 gaps inside MEASURE: counter holds, and the request fires after 4 total qualifying samples.
- Timeout:
  - Candidate BS3, no respond: request high exactly 16 cycles, then 0, `ho_fail_cnt`=1, target unchanged.
  - Repeat 300 times: `ho_fail_cnt` saturates at 255.
- Wrong and simultaneous responds:
  - Candidate BS2, `BS3_DM_respond`=1: ignored.
  - `BS2_DM_respond` on cycle 15, the timeout cycle: commit to target 2, `ho_fail_cnt` unchanged.
- Tie and saturation, plus mid-handshake reset:
  - Serving BS1, sq1=250, sq2=sq3=255: no qualify, since 255 < 258 with no 8-bit wrap.
  - Serving BS1, sq1=0, sq2=sq3=200: BS2 chosen.
  - Reset asserted during REQUEST: request drops immediately and target returns to INIT_TARGET.
